// File: rtl/propose_sweep_scheduler.sv
// propose_sweep_scheduler: sweeps enabled variables through the propose datapath and commits each result
module propose_sweep_scheduler #(
    parameter int NUM_VARS        = 3,
    parameter int VAR_INDEX_WIDTH = 2,
    parameter int VALUE_WIDTH     = 16,
    parameter int SWEEP_WIDTH     = 16,
    parameter int TIMEOUT         = 255
) (
    input  logic                       in_clk,
    input  logic                       in_reset,
    input  logic                       in_start,
    input  logic [SWEEP_WIDTH-1:0]     in_num_sweeps,
    input  logic [NUM_VARS-1:0]        in_var_mask,
    output logic                       out_propose_enable,
    output logic [VAR_INDEX_WIDTH-1:0] out_variable_index,
    input  logic                       in_propose_done,
    input  logic [VALUE_WIDTH-1:0]     in_assignment_new,
    output logic                       out_write_enable,
    output logic [VAR_INDEX_WIDTH-1:0] out_write_index,
    output logic [VALUE_WIDTH-1:0]     out_write_data,
    output logic                       out_busy,
    output logic                       out_done,
    output logic                       out_error,
    output logic [SWEEP_WIDTH-1:0]     out_sweep_count
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMMIT, DONE, ERROR} state_t;
    state_t                     state;
    logic [NUM_VARS-1:0]        mask;
    logic [SWEEP_WIDTH-1:0]     num_sweeps;
    logic [TW-1:0]              timer;
    logic [VAR_INDEX_WIDTH-1:0] next_idx;
    logic                       has_next;
    function automatic logic [VAR_INDEX_WIDTH-1:0] lowest(input logic [NUM_VARS-1:0] m);
        lowest = '0;
        for (int i = NUM_VARS - 1; i >= 0; i--)
            if (m[i]) lowest = VAR_INDEX_WIDTH'(i);
    endfunction
    assign out_write_index = out_variable_index;
    // find the next enabled variable above the one currently under proposal
    always_comb begin
        next_idx = '0;
        has_next = 1'b0;
        for (int i = NUM_VARS - 1; i >= 0; i--) begin
            if (mask[i] && i > int'(out_variable_index)) begin
                next_idx = VAR_INDEX_WIDTH'(i);
                has_next = 1'b1;
            end
        end
    end
    // sweep sequencer; strobes are registered alongside the state transition that implies them
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state              <= IDLE;
            mask               <= '0;
            num_sweeps         <= '0;
            timer              <= '0;
            out_propose_enable <= 1'b0;
            out_variable_index <= '0;
            out_write_enable   <= 1'b0;
            out_write_data     <= '0;
            out_busy           <= 1'b0;
            out_done           <= 1'b0;
            out_error          <= 1'b0;
            out_sweep_count    <= '0;
        end else begin
            out_propose_enable <= 1'b0;
            out_write_enable   <= 1'b0;
            out_done           <= 1'b0;
            case (state)
                IDLE: if (in_start) begin
                    mask            <= in_var_mask;
                    num_sweeps      <= in_num_sweeps;
                    out_sweep_count <= '0;
                    if (in_num_sweeps == '0 || in_var_mask == '0) begin
                        state    <= DONE;
                        out_done <= 1'b1;
                    end else begin
                        state              <= ISSUE;
                        out_variable_index <= lowest(in_var_mask);
                        out_propose_enable <= 1'b1;
                        out_busy           <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    timer <= '0;
                end
                WAIT: if (in_propose_done) begin
                    state            <= COMMIT;
                    out_write_data   <= in_assignment_new;
                    out_write_enable <= 1'b1;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state     <= ERROR;
                    out_busy  <= 1'b0;
                    out_error <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
                COMMIT: if (has_next) begin
                    state              <= ISSUE;
                    out_variable_index <= next_idx;
                    out_propose_enable <= 1'b1;
                end else begin
                    out_sweep_count <= out_sweep_count + 1'b1;
                    if (out_sweep_count + 1'b1 == num_sweeps) begin
                        state    <= DONE;
                        out_done <= 1'b1;
                        out_busy <= 1'b0;
                    end else begin
                        state              <= ISSUE;
                        out_variable_index <= lowest(mask);
                        out_propose_enable <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= ERROR;
            endcase
        end
    end
endmodule

// File: tb/tb_propose_sweep_scheduler.sv
// tb_propose_sweep_scheduler: directed vector table plus hand sequences for timeout and reset
module tb_propose_sweep_scheduler;
    logic        clk = 1'b0;
    logic        in_reset = 1'b1;
    logic        in_start = 1'b0;
    logic [15:0] in_num_sweeps = '0;
    logic [2:0]  in_var_mask = '0;
    logic        in_propose_done = 1'b0;
    logic [15:0] in_assignment_new = '0;
    logic        out_propose_enable, out_write_enable, out_busy, out_done, out_error;
    logic [1:0]  out_variable_index, out_write_index;
    logic [15:0] out_write_data, out_sweep_count;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    propose_sweep_scheduler dut (
        .in_clk(clk), .in_reset(in_reset), .in_start(in_start),
        .in_num_sweeps(in_num_sweeps), .in_var_mask(in_var_mask),
        .out_propose_enable(out_propose_enable), .out_variable_index(out_variable_index),
        .in_propose_done(in_propose_done), .in_assignment_new(in_assignment_new),
        .out_write_enable(out_write_enable), .out_write_index(out_write_index),
        .out_write_data(out_write_data), .out_busy(out_busy), .out_done(out_done),
        .out_error(out_error), .out_sweep_count(out_sweep_count)
    );

    // seq: k-th proposed index lives in nibble k (bits [4k+1:4k])
    typedef struct {
        logic [2:0]  mask;
        logic [15:0] nsw;
        int          delay;
        bit          done_in_issue;
        bit          restart;
        int          n;
        logic [31:0] seq;
        int          done_cyc;
        logic [15:0] count;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_case(input vec_t v);
        int n_en = 0;
        int n_wr = 0;
        int pend = -1;
        int done_at = -1;
        logic [15:0] q[$];
        logic [15:0] d;
        @(negedge clk);
        in_var_mask = v.mask;
        in_num_sweeps = v.nsw;
        in_start = 1'b1;
        for (int c = 1; c <= 400 && done_at < 0; c++) begin
            @(negedge clk);
            in_start = 1'b0;
            in_propose_done = 1'b0;
            in_assignment_new = 16'hDEAD;
            if (c == 1) check("busy_c1", out_busy, v.n > 0);
            if (v.restart && c == 5) begin
                in_start = 1'b1;
                in_var_mask = 3'b001;
                in_num_sweeps = 16'd7;
            end
            if (out_write_enable) begin
                check("wr_index", out_write_index, v.seq[4*n_wr +: 2]);
                d = (q.size() > 0) ? q.pop_front() : 16'hFFFF;
                check("wr_data", out_write_data, d);
                n_wr++;
            end
            if (out_propose_enable) begin
                check("en_cycle", c, 1 + (v.delay + 2) * n_en);
                check("en_index", out_variable_index, v.seq[4*n_en +: 2]);
                n_en++;
                pend = c + v.delay;
                if (v.done_in_issue) begin
                    in_propose_done = 1'b1;
                    in_assignment_new = 16'hBAD0;
                end
            end
            if (c == pend) begin
                d = 16'h1000 + 16'(n_en * 16'h111);
                in_propose_done = 1'b1;
                in_assignment_new = d;
                q.push_back(d);
                pend = -1;
            end
            if (out_done) begin
                done_at = c;
                check("busy_at_done", out_busy, 0);
            end
        end
        check("done_cycle", done_at, v.done_cyc);
        check("num_enables", n_en, v.n);
        check("num_writes", n_wr, v.n);
        check("sweep_count", out_sweep_count, v.count);
        repeat (2) @(negedge clk);
        check("count_hold", out_sweep_count, v.count);
        check("idle_quiet", {out_busy, out_propose_enable, out_write_enable, out_done}, 0);
    endtask

    initial begin
        //          mask    nsw delay issue rst  n  seq           done count
        vecs[0] = '{3'b111, 16'd2, 1, 1'b0, 1'b0, 6, 32'h00210210, 19, 16'd2};
        vecs[1] = '{3'b101, 16'd2, 1, 1'b0, 1'b0, 4, 32'h00002020, 13, 16'd2};
        vecs[2] = '{3'b111, 16'd0, 1, 1'b0, 1'b0, 0, 32'h0,         1, 16'd0};
        vecs[3] = '{3'b000, 16'd5, 1, 1'b0, 1'b0, 0, 32'h0,         1, 16'd0};
        vecs[4] = '{3'b010, 16'd3, 3, 1'b0, 1'b0, 3, 32'h00000111, 16, 16'd3};
        vecs[5] = '{3'b111, 16'd1, 1, 1'b1, 1'b1, 3, 32'h00000210, 10, 16'd1};
        vecs[6] = '{3'b110, 16'd1, 2, 1'b0, 1'b0, 2, 32'h00000021,  9, 16'd1};
        vecs[7] = '{3'b100, 16'd2, 1, 1'b0, 1'b0, 2, 32'h00000022,  7, 16'd2};

        repeat (2) @(negedge clk);
        check("rst_flags", {out_propose_enable, out_variable_index, out_write_enable,
                            out_write_index, out_busy, out_done, out_error}, 0);
        check("rst_data", out_write_data, 0);
        check("rst_count", out_sweep_count, 0);
        in_reset = 1'b0;

        for (int i = 0; i < 8; i++) run_case(vecs[i]);

        // timeout: done never arrives
        begin
            int n_wr = 0;
            int n_en = 0;
            @(negedge clk);
            in_var_mask = 3'b001;
            in_num_sweeps = 16'd1;
            in_start = 1'b1;
            for (int c = 1; c <= 257; c++) begin
                @(negedge clk);
                in_start = 1'b0;
                if (out_write_enable) n_wr++;
                if (c == 256) check("to_pre_err", {out_error, out_busy}, 2'b01);
                if (c == 257) check("to_err", {out_error, out_busy, out_propose_enable, out_write_enable}, 4'b1000);
            end
            check("to_no_write", n_wr, 0);
            in_start = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                in_start = 1'b0;
                if (out_propose_enable) n_en++;
            end
            check("to_start_ignored", n_en, 0);
            check("to_sticky", {out_error, out_busy}, 2'b10);
            in_reset = 1'b1;
            @(negedge clk);
            in_reset = 1'b0;
            check("to_cleared", {out_error, out_busy, out_done}, 0);
        end

        // reset while in WAIT, then a stray done
        begin
            int n_wr = 0;
            @(negedge clk);
            in_var_mask = 3'b111;
            in_num_sweeps = 16'd2;
            in_start = 1'b1;
            @(negedge clk);
            in_start = 1'b0;
            @(negedge clk);
            in_reset = 1'b1;
            @(negedge clk);
            in_reset = 1'b0;
            check("wr_rst_flags", {out_propose_enable, out_variable_index, out_write_enable,
                                   out_write_index, out_busy, out_done, out_error}, 0);
            check("wr_rst_data", out_write_data, 0);
            check("wr_rst_count", out_sweep_count, 0);
            in_propose_done = 1'b1;
            in_assignment_new = 16'h7777;
            @(negedge clk);
            in_propose_done = 1'b0;
            for (int c = 0; c < 3; c++) begin
                if (out_write_enable || out_busy) n_wr++;
                @(negedge clk);
            end
            check("stray_done", n_wr, 0);
            run_case(vecs[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
